bht_update_ctrl: RTL
====================

BHT_UPDATE_CTRL -- requirements
Module: bht_update_ctrl

Interface
REQ-001 SHALL have parameter SET_COUNT, default 32, number of BHT entries.
REQ-002 SHALL have parameter INDEX_WIDTH, default 5, BHT index width (log2 SET_COUNT).
REQ-003 SHALL have parameter QUEUE_DEPTH, default 4, power of two >= 2, pending-update queue depth.
REQ-004 SHALL have port i_clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port i_rst_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port i_stall_fetch  input  1  BHT write port unavailable this cycle.
REQ-007 SHALL have port i_upd_valid  input  1  execute-stage branch resolution offered.
REQ-008 SHALL have port i_upd_taken  input  1  resolved direction (1 = taken).
REQ-009 SHALL have port i_upd_index  input  INDEX_WIDTH  BHT set index of resolved branch.
REQ-010 SHALL have port i_clear_req  input  1  request to re-initialise the whole table.
REQ-011 SHALL have port o_upd_ready  output  1  update accepted when i_upd_valid & o_upd_ready.
REQ-012 SHALL have port o_wr_en  output  1  BHT write strobe.
REQ-013 SHALL have port o_wr_init  output  1  with o_wr_en: force entry to 2'b01 (weakly not taken).
REQ-014 SHALL have port o_wr_taken  output  1  with o_wr_en & ~o_wr_init: saturating increment (1) or decrement (0).
REQ-015 SHALL have port o_wr_index  output  INDEX_WIDTH  BHT entry written.
REQ-016 SHALL have port o_busy  output  1  clear sweep in progress.
REQ-017 SHALL have port o_pending  output  log2(QUEUE_DEPTH)+1  queued update count.

Function
REQ-018 SHALL implement FSM with states IDLE and CLEAR.
REQ-019 IDLE: o_upd_ready = ~full & ~i_clear_req (combinational; no dependence on i_stall_fetch).
REQ-020 Accepted update SHALL be enqueued {taken, index} in FIFO order; no same-cycle bypass, so earliest write is the next cycle.
REQ-021 IDLE, queue non-empty, ~i_stall_fetch: o_wr_en=1, o_wr_init=0, o_wr_taken/o_wr_index = head entry; head dequeued at clock edge.
REQ-022 IDLE with i_stall_fetch=1: o_wr_en=0, queue contents held.
REQ-023 Simultaneous enqueue and dequeue SHALL leave o_pending unchanged; full queue SHALL keep o_upd_ready=0 even if dequeuing that cycle.
REQ-024 Pointers SHALL wrap modulo QUEUE_DEPTH; o_pending ranges 0..QUEUE_DEPTH.
REQ-025 IDLE & i_clear_req: next state CLEAR, queue flushed (o_pending=0 next cycle), sweep counter=0; any same-cycle update not accepted.
REQ-026 CLEAR: o_upd_ready=0, o_busy=1; when ~i_stall_fetch: o_wr_en=1, o_wr_init=1, o_wr_index=sweep counter, counter increments.
REQ-027 CLEAR with i_stall_fetch=1: o_wr_en=0, counter held.
REQ-028 CLEAR SHALL return to IDLE after the write of index SET_COUNT-1; exactly SET_COUNT init writes per sweep.
REQ-029 i_clear_req while in CLEAR SHALL be ignored (no restart).
REQ-030 o_wr_taken and o_wr_index SHALL be 0 whenever o_wr_en=0.

Reset
REQ-031 While i_rst_n=0 at a clock edge: state IDLE, queue empty, sweep counter 0.
REQ-032 After reset: o_wr_en=0, o_wr_init=0, o_busy=0, o_pending=0, o_upd_ready=1 (unless i_clear_req).
REQ-033 Reset mid-sweep or with queued updates SHALL abandon them; no writes issued for them.

Structure
REQ-034 Package bht_ctrl_pkg SHALL hold the state enum (IDLE, CLEAR), the update-entry struct {taken, index}, and the reset-init counter constant 2'b01.
REQ-035 Queue SHALL be one sub-module bht_upd_fifo (parameterised depth/width, sync active-low reset, flush input).

Verification
REQ-036 Enqueue idx 3 taken, stall 0 -> next cycle o_wr_en=1, o_wr_index=3, o_wr_taken=1; o_pending 1->0.
REQ-037 Enqueue 4 updates with stall=1 -> o_pending=4, o_upd_ready=0, o_wr_en=0; release stall -> 4 writes in order, one per cycle.
REQ-038 Full queue, stall 0, i_upd_valid=1 -> o_upd_ready=0 that cycle, o_pending stays 4 then drains to 3.
REQ-039 Pulse i_clear_req with 2 queued -> o_pending=0, 32 init writes idx 0..31 (extended by stall cycles), then o_busy=0, o_upd_ready=1.
REQ-040 i_rst_n low at sweep index 10 -> next cycle o_wr_en=0, o_busy=0, o_pending=0.

Source files
------------

// File: rtl/bht_ctrl_pkg.sv
// Shared types and constants for the branch-history-table update controller.
package bht_ctrl_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } bht_state_e;

    // Widest index any instance may use; instances carry only INDEX_WIDTH bits.
    localparam int unsigned MAX_INDEX_WIDTH = 16;

    typedef struct packed {
        logic                       taken;
        logic [MAX_INDEX_WIDTH-1:0] index;
    } upd_entry_t;

    // Counter value written by a table clear (weakly not taken).
    localparam logic [1:0] BHT_INIT_CTR = 2'b01;

endpackage

// File: rtl/bht_upd_fifo.sv
// Pending-update FIFO: power-of-two depth, head visible combinationally,
// flush discards all entries in one cycle.
module bht_upd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 6
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign o_full  = (count_q == (PTR_W+1)'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_count = count_q;
    assign o_data  = mem_q[rd_ptr_q];
    assign push_ok = i_push & ~o_full;
    assign pop_ok  = i_pop & ~o_empty;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            always_ff @(posedge i_clk) begin
                if (push_ok && (wr_ptr_q == PTR_W'(gi))) begin
                    mem_q[gi] <= i_data;
                end
            end
        end
    endgenerate

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        count_d  = count_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/bht_update_ctrl.sv
// Sequences resolved-branch updates and whole-table clear sweeps onto the
// single BHT write port, yielding whenever fetch owns the port.
module bht_update_ctrl
    import bht_ctrl_pkg::*;
#(
    parameter int SET_COUNT   = 32,
    parameter int INDEX_WIDTH = 5,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_stall_fetch,
    input  logic                         i_upd_valid,
    input  logic                         i_upd_taken,
    input  logic [INDEX_WIDTH-1:0]       i_upd_index,
    input  logic                         i_clear_req,
    output logic                         o_upd_ready,
    output logic                         o_wr_en,
    output logic                         o_wr_init,
    output logic                         o_wr_taken,
    output logic [INDEX_WIDTH-1:0]       o_wr_index,
    output logic                         o_busy,
    output logic [$clog2(QUEUE_DEPTH):0] o_pending
);

    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(SET_COUNT - 1);

    bht_state_e               state_q, state_d;
    logic [INDEX_WIDTH-1:0]   sweep_q, sweep_d;
    logic [INDEX_WIDTH:0]     fifo_head;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     fifo_push;
    logic                     fifo_pop;
    logic                     fifo_flush;

    bht_upd_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (INDEX_WIDTH + 1)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (fifo_flush),
        .i_push  (fifo_push),
        .i_data  ({i_upd_taken, i_upd_index}),
        .i_pop   (fifo_pop),
        .o_data  (fifo_head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_count (o_pending)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        case (state_q)
            IDLE: begin
                if (i_clear_req) begin
                    state_d = CLEAR;
                    sweep_d = '0;
                end
            end
            CLEAR: begin
                // A clear request here is deliberately ignored: the sweep never restarts.
                if (!i_stall_fetch) begin
                    if (sweep_q == LAST_INDEX) begin
                        state_d = IDLE;
                    end else begin
                        sweep_d = sweep_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        o_upd_ready = 1'b0;
        o_wr_en     = 1'b0;
        o_wr_init   = 1'b0;
        o_wr_taken  = 1'b0;
        o_wr_index  = '0;
        o_busy      = 1'b0;
        fifo_push   = 1'b0;
        fifo_pop    = 1'b0;
        fifo_flush  = 1'b0;
        case (state_q)
            IDLE: begin
                o_upd_ready = ~fifo_full & ~i_clear_req;
                fifo_push   = i_upd_valid & o_upd_ready;
                fifo_pop    = ~fifo_empty & ~i_stall_fetch;
                fifo_flush  = i_clear_req;
                o_wr_en     = fifo_pop;
                o_wr_taken  = fifo_pop & fifo_head[INDEX_WIDTH];
                o_wr_index  = fifo_pop ? fifo_head[INDEX_WIDTH-1:0] : '0;
            end
            CLEAR: begin
                o_busy     = 1'b1;
                o_wr_en    = ~i_stall_fetch;
                o_wr_init  = ~i_stall_fetch;
                o_wr_index = i_stall_fetch ? '0 : sweep_q;
            end
            default: ;
        endcase
    end

endmodule
